// File: rtl/if_fetch_gen.sv
// if_fetch_gen: fetch address generator with prioritised redirects, pending redirect latch and epoch tagging
module if_fetch_gen #(
  parameter int          FETCH_WIDTH = 2,
  parameter logic [31:0] RESET_PC    = 32'hbfc00000,
  parameter logic [31:0] EX_VECTOR   = 32'hbfc00380,
  parameter int          EPOCH_W     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ex_taken,
  input  logic                   eret_taken,
  input  logic [31:0]            epc,
  input  logic                   br_err,
  input  logic [31:0]            br_target,
  input  logic                   pred_taken,
  input  logic [31:0]            pred_target,
  output logic                   req,
  output logic [31:0]            addr,
  output logic                   uncache,
  input  logic                   addr_ok,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [FETCH_WIDTH-1:0] out_mask,
  output logic                   out_ex,
  output logic [EPOCH_W-1:0]     out_epoch,
  output logic [EPOCH_W-1:0]     cur_epoch
);
  typedef enum logic {S_REQ, S_HOLD} state_t;
  localparam logic [31:0] GROUP = 32'(4 * FETCH_WIDTH);
  state_t state, state_next;
  logic [31:0] pc, pc_next, seq_pc, slot, in_target, pend_target;
  logic [1:0] in_kind, pend_kind;
  logic in_valid, pend_valid, use_in, advance, epoch_inc;
  logic [EPOCH_W-1:0] epoch_next;
  always_comb begin
    out_ex = pc[1:0] != 2'b00;
    req = !reset && state == S_REQ && !out_ex;
    out_valid = !reset && (state == S_HOLD || addr_ok || out_ex);
    advance = out_valid && out_ready;
    addr = pc[31:30] == 2'b10 ? {3'b000, pc[28:0]} : pc;
    uncache = pc[31:29] == 3'b101;
    out_pc = pc;
    epoch_inc = ex_taken || eret_taken || br_err;
    epoch_next = cur_epoch + EPOCH_W'(epoch_inc);
    in_valid = epoch_inc || (pred_taken && out_valid);
    in_kind = ex_taken ? 2'd3 : eret_taken ? 2'd2 : br_err ? 2'd1 : 2'd0;
    in_target = ex_taken ? EX_VECTOR : eret_taken ? epc : br_err ? br_target : pred_target;
    // equal priority overwrites, so the newest redirect of a kind wins
    use_in = in_valid && (!pend_valid || in_kind >= pend_kind);
    seq_pc = (pc & ~(GROUP - 32'd1)) + GROUP;
    pc_next = use_in ? in_target : pend_valid ? pend_target : seq_pc;
    state_next = advance ? S_REQ : out_valid ? S_HOLD : state;
    slot = (pc >> 2) & 32'(FETCH_WIDTH - 1);
    for (int i = 0; i < FETCH_WIDTH; i++) out_mask[i] = 32'(i) >= slot;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_REQ;
      pc <= RESET_PC;
      pend_valid <= 1'b0;
      pend_kind <= 2'd0;
      pend_target <= 32'd0;
      cur_epoch <= '0;
      out_epoch <= '0;
    end else begin
      state <= state_next;
      cur_epoch <= epoch_next;
      if (advance) begin
        pc <= pc_next;
        pend_valid <= 1'b0;
        out_epoch <= epoch_next;
      end else if (use_in) begin
        pend_valid <= 1'b1;
        pend_kind <= in_kind;
        pend_target <= in_target;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_gen.sv
// tb_if_fetch_gen: directed scenarios plus randomized traffic checked against a behavioural fetch model
module tb_if_fetch_gen;
  localparam int FW = 2;
  localparam logic [31:0] RST_PC = 32'hbfc00000;
  localparam logic [31:0] EXV = 32'hbfc00380;
  logic clk = 0, reset = 1;
  logic ex_taken = 0, eret_taken = 0, br_err = 0, pred_taken = 0, addr_ok = 0, out_ready = 0;
  logic [31:0] epc = 0, br_target = 0, pred_target = 0;
  logic req, uncache, out_valid, out_ex;
  logic [31:0] addr, out_pc;
  logic [FW-1:0] out_mask;
  logic [1:0] out_epoch, cur_epoch;
  int n_chk = 0, n_pass = 0;
  logic [31:0] m_pc = RST_PC, m_pt = 0;
  bit m_acc = 0, m_pv = 0;
  int m_pk = 0, m_ep = 0, m_oep = 0, e0;
  always #5 clk = ~clk;
  if_fetch_gen dut (
    .clk(clk), .reset(reset), .ex_taken(ex_taken), .eret_taken(eret_taken), .epc(epc),
    .br_err(br_err), .br_target(br_target), .pred_taken(pred_taken), .pred_target(pred_target),
    .req(req), .addr(addr), .uncache(uncache), .addr_ok(addr_ok), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_mask(out_mask), .out_ex(out_ex),
    .out_epoch(out_epoch), .cur_epoch(cur_epoch)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic logic [31:0] phys(input logic [31:0] a);
    return a[31:30] == 2'b10 ? {3'b000, a[28:0]} : a;
  endfunction
  function automatic logic [31:0] exp_mask(input logic [31:0] a);
    logic [31:0] m = 0;
    for (int i = 0; i < FW; i++) m[i] = i >= int'((a >> 2) % FW);
    return m;
  endfunction
  task automatic compare();
    bit mex = m_pc[1:0] != 0;
    bit mval = !reset && (m_acc || addr_ok || mex);
    check("req", 32'(req), 32'(!reset && !m_acc && !mex));
    check("out_valid", 32'(out_valid), 32'(mval));
    if (!reset) begin
      check("out_pc", out_pc, m_pc);
      check("addr", addr, phys(m_pc));
      check("uncache", 32'(uncache), 32'(m_pc[31:29] == 3'b101));
      check("out_ex", 32'(out_ex), 32'(mex));
      check("out_mask", 32'(out_mask), exp_mask(m_pc));
      check("out_epoch", 32'(out_epoch), 32'(m_oep));
      check("cur_epoch", 32'(cur_epoch), 32'(m_ep));
    end
  endtask
  task automatic update();
    bit mex, mval;
    int ik;
    logic [31:0] it;
    if (reset) begin
      m_pc = RST_PC; m_acc = 0; m_pv = 0; m_pk = 0; m_ep = 0; m_oep = 0;
      return;
    end
    mex = m_pc[1:0] != 0;
    mval = m_acc || addr_ok || mex;
    ik = -1; it = 0;
    if (ex_taken) begin ik = 3; it = EXV; end
    else if (eret_taken) begin ik = 2; it = epc; end
    else if (br_err) begin ik = 1; it = br_target; end
    else if (pred_taken && mval) begin ik = 0; it = pred_target; end
    if (ex_taken || eret_taken || br_err) m_ep = (m_ep + 1) % 4;
    if (mval && out_ready) begin
      if (ik >= 0 && (!m_pv || ik >= m_pk)) m_pc = it;
      else if (m_pv) m_pc = m_pt;
      else m_pc = (m_pc & ~32'(4 * FW - 1)) + 32'(4 * FW);
      m_acc = 0; m_pv = 0; m_oep = m_ep;
    end else begin
      if (mval) m_acc = 1;
      if (ik >= 0 && (!m_pv || ik >= m_pk)) begin m_pv = 1; m_pk = ik; m_pt = it; end
    end
  endtask
  task automatic tick();
    #2 compare();
    @(posedge clk);
    update();
    #1;
  endtask
  function automatic logic [31:0] rtarget();
    logic [31:0] bases [4] = '{32'h80000000, 32'ha0000000, 32'h00400000, 32'hbfc00000};
    logic [31:0] t = bases[$urandom_range(3)] + ($urandom & 32'h3ff);
    if ($urandom_range(7) != 0) t[1:0] = 2'b00;
    if ($urandom_range(31) == 0) t = 32'hfffffff8;
    return t;
  endfunction
  initial begin
    tick(); tick();
    #2 check("rst_cur_epoch", 32'(cur_epoch), 0);
    check("rst_out_epoch", 32'(out_epoch), 0);
    reset = 0; addr_ok = 1; out_ready = 1;
    #1 check("first_req", 32'(req), 1);
    check("first_addr", addr, 32'h1fc00000);
    for (int k = 0; k < 3; k++) begin
      check("seq_pc", out_pc, 32'hbfc00000 + 32'(8 * k));
      check("seq_addr", addr, 32'h1fc00000 + 32'(8 * k));
      check("seq_mask", 32'(out_mask), 32'h3);
      tick();
    end
    pred_taken = 1; pred_target = 32'h80000004;
    tick();
    pred_taken = 0;
    check("unal_pc", out_pc, 32'h80000004);
    check("unal_mask", 32'(out_mask), 32'h2);
    tick();
    check("unal_next", out_pc, 32'h80000008);
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_req", 32'(req), 0);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_pc", out_pc, 32'h80000008);
    end
    out_ready = 1;
    tick();
    check("resume_req", 32'(req), 1);
    check("resume_pc", out_pc, 32'h80000010);
    out_ready = 0; e0 = m_ep;
    br_err = 1; br_target = 32'h80001000; ex_taken = 1;
    tick();
    br_err = 0; ex_taken = 0; eret_taken = 1; epc = 32'h80002000;
    tick();
    eret_taken = 0; out_ready = 1;
    tick();
    check("prio_pc", out_pc, EXV);
    check("prio_epoch", 32'(cur_epoch), 32'((e0 + 2) % 4));
    br_err = 1; br_target = 32'h80000002;
    tick();
    br_err = 0; addr_ok = 0;
    #1 check("mis_ex", 32'(out_ex), 1);
    check("mis_req", 32'(req), 0);
    check("mis_valid", 32'(out_valid), 1);
    tick();
    e0 = m_ep;
    br_target = 32'h80000100;
    for (int k = 1; k <= 4; k++) begin
      br_err = 1;
      tick();
      br_err = 0;
      check("wrap_cur", 32'(cur_epoch), 32'((e0 + k) % 4));
      check("wrap_tag", 32'(out_epoch), 32'(e0));
    end
    addr_ok = 1;
    tick();
    check("wrap_pc", out_pc, 32'h80000100);
    for (int n = 0; n < 800; n++) begin
      reset = $urandom_range(99) == 0;
      addr_ok = $urandom_range(3) != 0;
      out_ready = $urandom_range(2) != 0;
      ex_taken = $urandom_range(29) == 0;
      eret_taken = $urandom_range(19) == 0;
      br_err = $urandom_range(9) == 0;
      pred_taken = $urandom_range(4) == 0;
      epc = rtarget(); br_target = rtarget(); pred_target = rtarget();
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
